// File: rtl/oam_dma_if.sv
// CPU bus bundle between the OAM DMA initiator and the bus it hijacks.
// master = DMA engine side, slave = CPU/bus fabric side.
interface oam_dma_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic [7:0]  mem_din;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_wr;
  logic        dma_done;

  modport master (
    input  bus_addr,
    input  bus_din,
    input  bus_wr,
    input  odd_or_even,
    input  mem_din,
    output dma_hijack,
    output dma_addr,
    output dma_dout,
    output dma_wr,
    output dma_done
  );

  modport slave (
    output bus_addr,
    output bus_din,
    output bus_wr,
    output odd_or_even,
    output mem_din,
    input  dma_hijack,
    input  dma_addr,
    input  dma_dout,
    input  dma_wr,
    input  dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// OAM sprite DMA: copies CPU page $XX00-$XXFF to OAM via $2004.
// Macro OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN dummy read.
module oam_dma #(
  parameter logic [15:0] PAGE_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic   cpu_clk,
  input logic   reset_n,
  oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        armed_q, armed_d;

  logic        hijack;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        wr;
  logic        done;

  logic        trig;

  // Page write seen by the engine; armed_q masks the release edge.
  assign trig = armed_q
              && (bus.bus_addr == PAGE_REG_ADDR)
              && !bus.bus_wr;

`ifndef OAM_DMA_ALIGN_EN
  logic unused_odd;
  assign unused_odd = bus.odd_or_even;
`endif

  // State and datapath registers.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      armed_q <= armed_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    armed_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          page_d  = bus.bus_din;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_d = bus.odd_or_even ? ALIGN : READ;
`else
        state_d = READ;
`endif
      end
      ALIGN: state_d = READ;
      READ: begin
        data_d  = bus.mem_din;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from registered state only.
  always_comb begin
    hijack = 1'b0;
    addr   = 16'h0000;
    dout   = 8'h00;
    wr     = 1'b1;
    done   = 1'b0;
    unique case (state_q)
      HALT, ALIGN: begin
        hijack = 1'b1;
        addr   = {page_q, 8'h00};
      end
      READ: begin
        hijack = 1'b1;
        addr   = {page_q, idx_q};
      end
      WRITE: begin
        hijack = 1'b1;
        addr   = OAM_DATA_ADDR;
        dout   = data_q;
        wr     = 1'b0;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.dma_hijack = hijack;
  assign bus.dma_addr   = addr;
  assign bus.dma_dout   = dout;
  assign bus.dma_wr     = wr;
  assign bus.dma_done   = done;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma.
// Memory returns addr[7:0], so byte n written to OAM must equal n.
module tb_oam_dma;

  logic clk;
  logic rst_n;

  oam_dma_if bus();

  oam_dma dut (
    .cpu_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  assign bus.mem_din = bus.dma_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  int hij_cnt;
  int wr_cnt;
  int done_cnt;
  int bad_cnt;
  logic [15:0] prev_addr;
  logic [15:0] first_rd;
  logic [15:0] last_rd;
  logic [7:0]  exp_page;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: counts cycles and checks each OAM write.
  always @(negedge clk) begin
    if (bus.dma_hijack) hij_cnt++;
    if (bus.dma_done) done_cnt++;
    if (!bus.dma_wr) begin
      if (bus.dma_addr != 16'h2004) bad_cnt++;
      if (bus.dma_dout != wr_cnt[7:0]) bad_cnt++;
      if (prev_addr != {exp_page, wr_cnt[7:0]}) bad_cnt++;
      if (wr_cnt == 0) first_rd = prev_addr;
      last_rd = prev_addr;
      wr_cnt++;
    end
    prev_addr = bus.dma_addr;
  end

  function automatic int exp_len(input logic odd);
`ifdef OAM_DMA_ALIGN_EN
    return odd ? 514 : 513;
`else
    return 513;
`endif
  endfunction

  task automatic bus_idle();
    bus.bus_addr = 16'h0000;
    bus.bus_wr   = 1'b1;
    bus.bus_din  = 8'h00;
  endtask

  task automatic clr_mon();
    hij_cnt  = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    bad_cnt  = 0;
    first_rd = 16'h0;
    last_rd  = 16'h0;
  endtask

  task automatic start_xfer(input logic [7:0] pg,
                            input logic odd);
    @(negedge clk);
    clr_mon();
    exp_page        = pg;
    bus.odd_or_even = odd;
    bus.bus_addr    = 16'h4014;
    bus.bus_wr      = 1'b0;
    bus.bus_din     = pg;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tmo"}, 32'(n >= 700), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hij"}, 32'(bus.dma_hijack), 32'd0);
    chk({tag, "_wr"}, 32'(bus.dma_wr), 32'd1);
    chk({tag, "_adr"}, 32'(bus.dma_addr), 32'd0);
    chk({tag, "_do"}, 32'(bus.dma_dout), 32'd0);
    chk({tag, "_dn"}, 32'(bus.dma_done), 32'd0);
  endtask

  task automatic chk_xfer(input string tag,
                          input logic [7:0] pg,
                          input int len);
    chk({tag, "_len"}, 32'(hij_cnt), 32'(len));
    chk({tag, "_nwr"}, 32'(wr_cnt), 32'd256);
    chk({tag, "_ndn"}, 32'(done_cnt), 32'd1);
    chk({tag, "_bad"}, 32'(bad_cnt), 32'd0);
    chk({tag, "_rd0"}, 32'(first_rd), {16'h0, pg, 8'h00});
    chk({tag, "_rdN"}, 32'(last_rd), {16'h0, pg, 8'hFF});
    chk_idle(tag);
  endtask

  initial begin
    int n;
    n_chk = 0;
    n_err = 0;
    exp_page = 8'h00;
    prev_addr = 16'h0;
    clr_mon();
    rst_n = 1'b0;
    bus.odd_or_even = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    chk_idle("rst");

    // Trigger coinciding with reset release must be ignored.
    bus.bus_addr = 16'h4014;
    bus.bus_wr   = 1'b0;
    bus.bus_din  = 8'h05;
    rst_n        = 1'b1;
    @(negedge clk);
    bus_idle();
    clr_mon();
    repeat (4) @(negedge clk);
    chk("reltrig_hij", 32'(hij_cnt), 32'd0);

    // Even-cycle transfer from page $02.
    start_xfer(8'h02, 1'b0);
    wait_done("even");
    chk_xfer("even", 8'h02, exp_len(1'b0));

    // Odd-cycle transfer: ALIGN dummy when enabled.
    start_xfer(8'h02, 1'b1);
    wait_done("odd");
    chk_xfer("odd", 8'h02, exp_len(1'b1));

    // Second page write during transfer is ignored.
    start_xfer(8'h02, 1'b0);
    n = 0;
    while (wr_cnt < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.bus_addr = 16'h4014;
    bus.bus_wr   = 1'b0;
    bus.bus_din  = 8'h03;
    @(negedge clk);
    bus_idle();
    wait_done("retrig");
    chk_xfer("retrig", 8'h02, exp_len(1'b0));

    // Reset in the WRITE cycle of idx 100.
    start_xfer(8'h04, 1'b0);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      if (!bus.dma_wr && wr_cnt == 100) break;
      n++;
    end
    chk("mid_reach", 32'(n >= 400), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_idle("mid");
    repeat (3) @(negedge clk);
    chk("mid_ndn", 32'(done_cnt), 32'd0);
    chk("mid_nwr", 32'(wr_cnt), 32'd100);
    rst_n = 1'b1;
    start_xfer(8'h04, 1'b0);
    wait_done("after");
    chk_xfer("after", 8'h04, exp_len(1'b0));

    // Read of $4014 and write of $4015 never trigger.
    @(negedge clk);
    clr_mon();
    bus.bus_addr = 16'h4014;
    bus.bus_wr   = 1'b1;
    bus.bus_din  = 8'h07;
    @(negedge clk);
    bus.bus_addr = 16'h4015;
    bus.bus_wr   = 1'b0;
    @(negedge clk);
    bus_idle();
    repeat (4) @(negedge clk);
    chk("notrig_hij", 32'(hij_cnt), 32'd0);
    chk_idle("notrig");

    // PPU register page reads through.
    start_xfer(8'h20, 1'b0);
    wait_done("ppu");
    chk_xfer("ppu", 8'h20, exp_len(1'b0));

    // Top page: last read at $FFFF, no overrun.
    start_xfer(8'hFF, 1'b0);
    wait_done("top");
    chk_xfer("top", 8'hFF, exp_len(1'b0));
    clr_mon();
    repeat (5) @(negedge clk);
    chk("top_quiet", 32'(hij_cnt + wr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
